// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory stage.
// Holds the RV32 load/store width codes, the access FSM state type,
// lane geometry constants and small decode helpers used by mem_stage
// and load_extend.
package mem_pkg;

    // RV32 funct3 width codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Lane geometry of a little-endian 32-bit word
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Byte-offset masks that force natural alignment
    localparam logic [1:0] HALF_OFF_MASK = 2'b10;
    localparam logic [1:0] WORD_OFF_MASK = 2'b00;

    // Access FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    // True for halfword-sized codes (signed or unsigned)
    function automatic logic is_half(input logic [2:0] funct3);
        return (funct3 == F3_H) || (funct3 == F3_HU);
    endfunction

    // True when the width code exists for the given direction
    function automatic logic is_supported(input logic we, input logic [2:0] funct3);
        logic ok;
        ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        if (!we) begin
            ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

    // True when the byte offset breaks natural alignment for the width
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (is_half(funct3)) begin
            bad = off[0];
        end else if (funct3 == F3_W) begin
            bad = (off != 2'b00);
        end
        return bad;
    endfunction

    // Byte offset with the low bits cleared to the access's natural alignment
    function automatic logic [1:0] align_off(input logic [2:0] funct3, input logic [1:0] off);
        logic [1:0] res;
        res = off;
        if (is_half(funct3)) begin
            res = off & HALF_OFF_MASK;
        end else if (funct3 == F3_W) begin
            res = off & WORD_OFF_MASK;
        end
        return res;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational lane select and sign/zero extension of a
// RAM word for LB/LH/LW/LBU/LHU, using the byte offset of the access.
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    // Pick the addressed byte and halfword lanes out of the word
    always_comb begin
        byte_sel = word[7:0];
        case (byte_off)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane to 32 bits according to the width code
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            F3_BU:   data = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
            F3_H:    data = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            F3_HU:   data = {{(WORD_W-HALF_W){1'b0}}, half_sel};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: single-outstanding load/store unit between the execute stage
// and a combinational-read data RAM. Loads take IDLE->RD->RESP, word
// stores IDLE->WR->RESP, byte/half stores do a read-modify-write through
// IDLE->RD->WR->RESP. Faulting requests go straight IDLE->RESP.
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN: when defined, misaligned
// accesses are reported with resp_err and never touch the RAM; when
// undefined, the low address bits are cleared to natural alignment.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    mem_state_t  state;

    // Request fields captured at accept time
    logic        q_we;
    logic [2:0]  q_funct3;
    logic [1:0]  q_off;
    logic [31:0] q_wdata;

    // Accept-time decode of the incoming request
    logic              req_fault;
    logic [1:0]        acc_off;
    logic [ADDR_W-1:0] acc_word;

    logic [31:0] load_data;
    logic [31:0] merged;

    // Classify the incoming request and derive the word/byte address to use
    always_comb begin
        acc_word = req_addr[ADDR_W+1:2];
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        req_fault = !is_supported(req_we, req_funct3)
                  || is_misaligned(req_funct3, req_addr[1:0]);
        acc_off   = req_addr[1:0];
`else
        req_fault = !is_supported(req_we, req_funct3);
        acc_off   = align_off(req_funct3, req_addr[1:0]);
`endif
    end

    // Lane select and extension of the word read during RD
    load_extend u_load_extend (
        .funct3   (q_funct3),
        .byte_off (q_off),
        .word     (ram_rdata),
        .data     (load_data)
    );

    // Splice the store byte/halfword into the word read during RD
    always_comb begin
        merged = ram_rdata;
        case (q_funct3)
            F3_B: begin
                case (q_off)
                    2'd0: merged[7:0]   = q_wdata[7:0];
                    2'd1: merged[15:8]  = q_wdata[7:0];
                    2'd2: merged[23:16] = q_wdata[7:0];
                    2'd3: merged[31:24] = q_wdata[7:0];
                    default: merged = ram_rdata;
                endcase
            end
            F3_H: begin
                if (q_off[1]) begin
                    merged[31:16] = q_wdata[15:0];
                end else begin
                    merged[15:0] = q_wdata[15:0];
                end
            end
            default: merged = q_wdata;
        endcase
    end

    // Access FSM with all handshake, response and RAM outputs registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            q_we       <= 1'b0;
            q_funct3   <= '0;
            q_off      <= '0;
            q_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        q_we      <= req_we;
                        q_funct3  <= req_funct3;
                        q_off     <= acc_off;
                        q_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            ram_addr  <= acc_word;
                            ram_wdata <= req_wdata;
                            ram_we    <= 1'b1;
                            state     <= WR;
                        end else begin
                            ram_addr <= acc_word;
                            state    <= RD;
                        end
                    end
                end
                RD: begin
                    if (q_we) begin
                        ram_wdata <= merged;
                        ram_we    <= 1'b1;
                        state     <= WR;
                    end else begin
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    ram_we     <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    ram_we    <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with a
// behavioural combinational-read RAM attached to the RAM port.
module tb_mem_stage;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int checkCount = 0;
    int passCount  = 0;

    // Results of the most recent transaction
    int          latency;
    int          weCount;
    logic [31:0] weAddr;
    logic [31:0] weData;
    logic [31:0] respData;
    logic        respErr;

    mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the rising edge
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request and follow it to its response, recording RAM writes
    task automatic applyStimulus(input bit syncNeg, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bit done;
        if (syncNeg) @(negedge clk);
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'hDEAD_BEEF;
        latency  = 0;
        weCount  = 0;
        weAddr   = '0;
        weData   = '0;
        respData = '0;
        respErr  = 1'b0;
        done     = 1'b0;
        for (int n = 1; n <= 8 && !done; n++) begin
            @(negedge clk);
            if (ram_we) begin
                weCount++;
                weAddr = 32'(ram_addr);
                weData = ram_wdata;
            end
            if (resp_valid) begin
                latency  = n;
                respData = resp_rdata;
                respErr  = resp_err;
                done     = 1'b1;
            end
        end
        if (!done) checkOutput("resp_valid_timeout", 32'(resp_valid), 1);
    endtask

    initial begin
        int badWe;
        int badResp;
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;

        // Reset values while rstn is held low
        #12;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        checkOutput("rst_resp_rdata", resp_rdata, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", 32'(ram_addr), 0);
        checkOutput("rst_ram_wdata", ram_wdata, 0);
        @(negedge clk);
        rstn = 1'b1;

        // SW 0xDC then LW 0xDC
        applyStimulus(1, 1'b1, 3'b010, 32'h0000_00DC, 32'd23);
        checkOutput("sw_latency", latency, 2);
        checkOutput("sw_we_count", weCount, 1);
        checkOutput("sw_we_addr", weAddr, 55);
        checkOutput("sw_we_data", weData, 23);
        checkOutput("sw_err", respErr, 0);
        applyStimulus(1, 1'b0, 3'b010, 32'h0000_00DC, 32'h0);
        checkOutput("lw_latency", latency, 2);
        checkOutput("lw_rdata", respData, 23);
        checkOutput("lw_we_count", weCount, 0);

        // Byte read-modify-write
        applyStimulus(1, 1'b1, 3'b010, 32'h0000_0080, 32'h1122_3344);
        applyStimulus(1, 1'b1, 3'b000, 32'h0000_0081, 32'h0000_00AA);
        checkOutput("sb_latency", latency, 3);
        checkOutput("sb_we_count", weCount, 1);
        checkOutput("sb_we_data", weData, 32'h1122_AA44);
        applyStimulus(1, 1'b0, 3'b010, 32'h0000_0080, 32'h0);
        checkOutput("lw_after_sb", respData, 32'h1122_AA44);

        // Upper halfword store
        applyStimulus(1, 1'b1, 3'b001, 32'h0000_0082, 32'h0000_5566);
        checkOutput("sh_latency", latency, 3);
        checkOutput("sh_we_data", weData, 32'h5566_AA44);

        // Sign and zero extension
        applyStimulus(1, 1'b1, 3'b010, 32'h0000_0080, 32'h0000_F080);
        applyStimulus(1, 1'b0, 3'b000, 32'h0000_0080, 32'h0);
        checkOutput("lb_80", respData, 32'hFFFF_FF80);
        applyStimulus(1, 1'b0, 3'b100, 32'h0000_0080, 32'h0);
        checkOutput("lbu_80", respData, 32'h0000_0080);
        applyStimulus(1, 1'b0, 3'b001, 32'h0000_0080, 32'h0);
        checkOutput("lh_80", respData, 32'hFFFF_F080);
        applyStimulus(1, 1'b0, 3'b101, 32'h0000_0080, 32'h0);
        checkOutput("lhu_80", respData, 32'h0000_F080);
        applyStimulus(1, 1'b0, 3'b000, 32'h0000_0081, 32'h0);
        checkOutput("lb_81", respData, 32'hFFFF_FFF0);
        applyStimulus(1, 1'b0, 3'b100, 32'h0000_0083, 32'h0);
        checkOutput("lbu_83", respData, 32'h0000_0000);

        // Misaligned word load
        applyStimulus(1, 1'b1, 3'b010, 32'h0000_001C, 32'hCAFE_BABE);
        applyStimulus(1, 1'b0, 3'b010, 32'h0000_001D, 32'h0);
        checkOutput("mis_we_count", weCount, 0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        checkOutput("mis_err", respErr, 1);
        checkOutput("mis_rdata", respData, 0);
        checkOutput("mis_latency", latency, 1);
`else
        checkOutput("mis_err", respErr, 0);
        checkOutput("mis_rdata", respData, 32'hCAFE_BABE);
        checkOutput("mis_latency", latency, 2);
`endif

        // Unsupported width codes
        applyStimulus(1, 1'b0, 3'b011, 32'h0000_001C, 32'h0);
        checkOutput("unsup_ld_err", respErr, 1);
        checkOutput("unsup_ld_rdata", respData, 0);
        checkOutput("unsup_ld_latency", latency, 1);
        applyStimulus(1, 1'b1, 3'b100, 32'h0000_001C, 32'h1234_5678);
        checkOutput("unsup_st_err", respErr, 1);
        checkOutput("unsup_st_we_count", weCount, 0);
        applyStimulus(1, 1'b0, 3'b010, 32'h0000_001C, 32'h0);
        checkOutput("unsup_st_no_write", respData, 32'hCAFE_BABE);

        // Reset during the RD phase of a halfword store
        applyStimulus(1, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rd_rst_req_ready", req_ready, 1);
        checkOutput("rd_rst_ram_we", ram_we, 0);
        checkOutput("rd_rst_resp_valid", resp_valid, 0);
        badWe   = 0;
        badResp = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (ram_we) badWe++;
            if (resp_valid) badResp++;
        end
        rstn = 1'b0;
        rstn = 1'b1;
        for (int n = 0; n < 1; n++) begin
            applyStimulus(0, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
            if (ram_we) badWe++;
        end
        checkOutput("rd_rst_we_seen", badWe + weCount, 0);
        checkOutput("rd_rst_resp_seen", badResp, 0);
        checkOutput("post_rst_latency", latency, 2);
        checkOutput("post_rst_lw", respData, 32'h1234_5678);

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $display("%0d/%0d checks passed", passCount, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width driven to the data RAM.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width; only 32 supported.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  access request from execute stage.
REQ-006 req_ready  out  1  request accepted when req_valid&&req_ready at clock edge.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_funct3  in  3  RV32 width code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse; consumer always ready.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  misaligned access, qualified by resp_valid.
REQ-014 ram_we  out  1  write enable to data RAM.
REQ-015 ram_addr  out  ADDR_W  word address, req_addr[ADDR_W+1:2]; higher bits ignored.
REQ-016 ram_wdata  out  32  full word to write.
REQ-017 ram_rdata  in  32  RAM read data, combinational from ram_addr (same cycle).

Function
REQ-018 FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-019 On accept, SHALL register we, funct3, addr, wdata; inputs thereafter ignored until back in IDLE.
REQ-020 Load: IDLE->RD->RESP; ram_rdata captured at end of RD; resp_valid 2 cycles after accept.
REQ-021 SW: IDLE->WR->RESP; ram_we=1 for exactly the WR cycle with ram_wdata=wdata; resp_valid 2 cycles after accept.
REQ-022 SB/SH: IDLE->RD->WR->RESP read-modify-write; only addressed byte/halfword replaced, little-endian lanes; resp_valid 3 cycles after accept.
REQ-023 Loads SHALL select lane by addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU.
REQ-024 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0): no RAM access, IDLE->RESP, resp_err=1, resp_rdata=0 (see REQ-031).
REQ-025 Unsupported funct3 SHALL be treated as misaligned (resp_err=1, no RAM write).
REQ-026 RESP->IDLE unconditionally; next request accepted in the cycle after RESP (max one access per 3-4 cycles).
REQ-027 ram_we SHALL be 0 in every state except WR.

Reset
REQ-028 rstn low SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-029 Reset asserted during RD or WR SHALL abort the access with no write completed after the reset edge and no resp_valid.
REQ-030 First request SHALL be accepted on the first rising edge after rstn deasserts.

Configuration
REQ-031 Macro MEM_STAGE_MISALIGN_TRAP_EN defined: misaligned handled per REQ-024; undefined: addr low bits forced to natural alignment (addr[0] cleared for half, addr[1:0] cleared for word), access proceeds normally, resp_err tied 0 (REQ-025 still flags unsupported funct3).

Structure
REQ-032 Shared package mem_pkg SHALL hold funct3 encodings, state enum type, and lane-select helper constants.
REQ-033 Sub-module load_extend SHALL perform lane select plus sign/zero extension (combinational); store merge stays in mem_stage.

Verification
REQ-034 SW addr 0xDC data 23, then LW addr 0xDC -> ram_we one cycle at ram_addr 55; load resp_rdata=23 two cycles after accept.
REQ-035 SW 0x80 data 0x11223344; SB addr 0x81 data 0xAA; LW 0x80 -> 0x1122AA44; SB latency 3 cycles.
REQ-036 Word 0x80 = 0x0000F080: LB 0x80 -> 0xFFFFFF80, LBU 0x80 -> 0x00000080, LH 0x80 -> 0xFFFFF080, LHU 0x80 -> 0x0000F080.
REQ-037 With trap enabled, LW addr 0x1D -> resp_err=1, resp_rdata=0, ram_we never asserted; without macro, same request returns word at 0x1C, resp_err=0.
REQ-038 SH 0x40 issued, rstn pulsed low during RD -> ram_we stays 0, no resp_valid, req_ready=1 during reset; later LW 0x40 returns pre-reset contents.
